// File: rtl/sobel_out_pkg.sv
// Shared definitions for the Sobel output packer: register offsets, field positions,
// and the APB access decoder.
package sobel_out_pkg;

  localparam logic [4:0] REG_DATA   = 5'h00;
  localparam logic [4:0] REG_STATUS = 5'h04;
  localparam logic [4:0] REG_CTRL   = 5'h08;
  localparam logic [4:0] REG_PIXCNT = 5'h0C;

  localparam int unsigned ST_EMPTY = 0;
  localparam int unsigned ST_FULL  = 1;
  localparam int unsigned ST_OVF   = 2;
  localparam int unsigned ST_FDONE = 3;
  localparam int unsigned ST_PEND  = 4;
  localparam int unsigned ST_LEVEL = 8;

  localparam int unsigned CTRL_CLR_OVF = 0;
  localparam int unsigned CTRL_CLR_FD  = 1;
  localparam int unsigned CTRL_FLUSH   = 2;

  typedef struct packed {
    logic rd_data;
    logic rd_status;
    logic rd_pixcnt;
    logic wr_ctrl;
    logic err;
  } apb_dec_t;

  // Classifies an access-phase transfer; an empty-FIFO DATA read is an error, not a pop.
  function automatic apb_dec_t apb_decode(input logic access, input logic write,
                                          input logic [4:0] addr, input logic fifo_empty);
    apb_dec_t d;
    d = '0;
    if (access) begin
      case (addr)
        REG_DATA: begin
          if (write || fifo_empty) d.err = 1'b1;
          else                     d.rd_data = 1'b1;
        end
        REG_STATUS: begin
          if (write) d.err = 1'b1;
          else       d.rd_status = 1'b1;
        end
        REG_CTRL: begin
          if (write) d.wr_ctrl = 1'b1;
          else       d.err = 1'b1;
        end
        REG_PIXCNT: begin
          if (write) d.err = 1'b1;
          else       d.rd_pixcnt = 1'b1;
        end
        default: d.err = 1'b1;
      endcase
    end
    return d;
  endfunction

endpackage

// File: rtl/sobel_out_fifo.sv
// Synchronous FIFO with show-ahead head, occupancy level, synchronous clear and
// an overflow strobe for a push that had to be dropped.
module sobel_out_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 32,
  localparam int unsigned AW    = $clog2(DEPTH),
  localparam int unsigned LVL_W = AW + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [LVL_W-1:0] level_o,
  output logic             overflow_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] cnt_q, cnt_d;
  logic             wr_en, rd_en;

  assign full_o  = (cnt_q == LVL_W'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign level_o = cnt_q;
  assign data_o  = mem_q[rd_ptr_q];

  // When full, a simultaneous pop frees the slot the push needs.
  assign wr_en      = push_i & (~full_o | pop_i) & ~clear_i;
  assign rd_en      = pop_i & ~empty_o & ~clear_i;
  assign overflow_o = push_i & full_o & ~pop_i & ~clear_i;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (clear_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (wr_en) wr_ptr_d = wr_ptr_q + AW'(1);
      if (rd_en) rd_ptr_d = rd_ptr_q + AW'(1);
      cnt_d = cnt_q + LVL_W'(wr_en) - LVL_W'(rd_en);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/sobel_out_packer.sv
// Packs the Sobel edge-pixel stream into little-endian 32-bit words, queues them in a FIFO
// and exposes the FIFO plus status/control registers over APB.
module sobel_out_packer
  import sobel_out_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 16,
  localparam int unsigned LVL_W     = $clog2(FIFO_DEPTH) + 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  pixel_in,
  input  logic        valid_in,
  input  logic        frame_done,
  input  logic        PSEL,
  input  logic        PENABLE,
  input  logic        PWRITE,
  input  logic [31:0] PADDR,
  input  logic [31:0] PWDATA,
  output logic [31:0] PRDATA,
  output logic        PREADY,
  output logic        PSLVERR,
  output logic        irq
);

  logic [31:0]      word_q, word_d, word_next;
  logic [1:0]       cnt_q, cnt_d;
  logic [2:0]       cnt_next;
  logic             fd_q;
  logic             ovf_q, ovf_d;
  logic             fdone_q, fdone_d;
  logic [31:0]      pixcnt_q, pixcnt_d;

  apb_dec_t         dec;
  logic             fd_rise, flush, accept, pack_push, fifo_pop;
  logic             clr_ovf, clr_fd;
  logic [31:0]      fifo_head;
  logic             fifo_full, fifo_empty, fifo_ovf;
  logic [LVL_W-1:0] fifo_level;
  logic [31:0]      status;
  logic             unused;

  assign unused  = ^{PADDR[31:5], PWDATA[31:3]};
  assign PREADY  = 1'b1;

  assign dec     = apb_decode(PSEL & PENABLE, PWRITE, PADDR[4:0], fifo_empty);
  assign flush   = dec.wr_ctrl & PWDATA[CTRL_FLUSH];
  assign clr_ovf = dec.wr_ctrl & PWDATA[CTRL_CLR_OVF];
  assign clr_fd  = dec.wr_ctrl & PWDATA[CTRL_CLR_FD];
  assign fd_rise = frame_done & ~fd_q;
  assign accept  = valid_in & ~flush;
  assign fifo_pop = dec.rd_data & ~flush;

  // Bytes above the pending count stay zero, so a frame-end flush is already padded.
  always_comb begin
    word_next = word_q;
    cnt_next  = {1'b0, cnt_q};
    if (accept) begin
      word_next[{cnt_q, 3'b000} +: 8] = pixel_in;
      cnt_next = cnt_next + 3'd1;
    end
    pack_push = (cnt_next == 3'd4) | (fd_rise & (cnt_next != 3'd0));
    if (pack_push || flush) begin
      word_d = '0;
      cnt_d  = '0;
    end else begin
      word_d = word_next;
      cnt_d  = cnt_next[1:0];
    end
  end

  always_comb begin
    pixcnt_d = pixcnt_q + 32'(accept);
    ovf_d    = fifo_ovf | (ovf_q & ~clr_ovf);
    fdone_d  = fd_rise | (fdone_q & ~clr_fd);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      word_q   <= '0;
      cnt_q    <= '0;
      fd_q     <= 1'b0;
      ovf_q    <= 1'b0;
      fdone_q  <= 1'b0;
      pixcnt_q <= '0;
    end else begin
      word_q   <= word_d;
      cnt_q    <= cnt_d;
      fd_q     <= frame_done;
      ovf_q    <= ovf_d;
      fdone_q  <= fdone_d;
      pixcnt_q <= pixcnt_d;
    end
  end

  sobel_out_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (32)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .clear_i    (flush),
    .push_i     (pack_push),
    .data_i     (word_next),
    .pop_i      (fifo_pop),
    .data_o     (fifo_head),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty),
    .level_o    (fifo_level),
    .overflow_o (fifo_ovf)
  );

  always_comb begin
    status                      = '0;
    status[ST_EMPTY]            = fifo_empty;
    status[ST_FULL]             = fifo_full;
    status[ST_OVF]              = ovf_q;
    status[ST_FDONE]            = fdone_q;
    status[ST_PEND +: 2]        = cnt_q;
    status[ST_LEVEL +: LVL_W]   = fifo_level;
  end

  always_comb begin
    PRDATA = '0;
    if (dec.rd_data)   PRDATA = fifo_head;
    if (dec.rd_status) PRDATA = status;
    if (dec.rd_pixcnt) PRDATA = pixcnt_q;
  end

  assign PSLVERR = dec.err;
  assign irq     = ~fifo_empty | fdone_q;

endmodule
